// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between two
// byte-stream requesters; the owner keeps the transmitter until a `last` byte or an idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_last,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [1:0]            grant,
  output logic                  timeout_pulse
);

  localparam int unsigned CW = $clog2(IDLE_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_OWN       = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  tmo_q, tmo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic                  own_valid, own_last, ready_own, accept;
  logic [DATA_WIDTH-1:0] own_data;

  assign own_valid = owner_q ? req1_valid : req0_valid;
  assign own_last  = owner_q ? req1_last  : req0_last;
  assign own_data  = owner_q ? req1_data  : req0_data;
  assign ready_own = (state_q == S_OWN) && !tx_busy;
  assign accept    = ready_own && own_valid;

  assign req0_ready    = ready_own && !owner_q;
  assign req1_ready    = ready_own && owner_q;
  assign tx_start      = (state_q == S_START);
  assign tx_data       = tx_data_q;
  assign timeout_pulse = tmo_q;
  // Grant is derived from state so asynchronous reset clears it at once.
  assign grant = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tmo_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d = (req0_valid && req1_valid) ? prio_q : req1_valid;
          cnt_d   = '0;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (accept) begin
          tx_data_d = own_data;
          last_d    = own_last;
          cnt_d     = '0;
          state_d   = S_START;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          prio_d  = ~owner_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            prio_d  = ~owner_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_OWN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes, a transmitter
// model answers tx_start, and a monitor checks each started byte against expectations.
module tb_uart_tx_arbiter;

  localparam int unsigned BUSY_LEN = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [7:0] req0_data = '0, req1_data = '0, tx_data;
  logic       tx_start, tx_busy, timeout_pulse;
  logic [1:0] grant;
  logic       model_busy = 1'b0, force_busy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int tmo_count = 0;

  logic [8:0] q0[$];   // {last, data}
  logic [8:0] q1[$];
  logic [9:0] exp_q[$]; // {grant, data}

  assign tx_busy = model_busy | force_busy;

  uart_tx_arbiter #(.DATA_WIDTH(8), .IDLE_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Requester drivers: present queue head, pop once accepted.
  initial forever begin
    @(negedge clk);
    req0_valid = (q0.size() > 0);
    if (q0.size() > 0) begin req0_data = q0[0][7:0]; req0_last = q0[0][8]; end
    req1_valid = (q1.size() > 0);
    if (q1.size() > 0) begin req1_data = q1[0][7:0]; req1_last = q1[0][8]; end
    #1;
    if (!reset && req0_valid && req0_ready) void'(q0.pop_front());
    if (!reset && req1_valid && req1_ready) void'(q1.pop_front());
  end

  // Transmitter model: busy rises one cycle after start and lasts BUSY_LEN cycles.
  initial begin
    int unsigned bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (tx_start) bcnt = BUSY_LEN + 1;
      else if (bcnt > 0) bcnt--;
      model_busy = (bcnt > 0) && (bcnt <= BUSY_LEN);
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (req0_ready) chk("r0_ready_owner", 32'(grant), 32'(2'b01));
      if (req1_ready) chk("r1_ready_owner", 32'(grant), 32'(2'b10));
      if (timeout_pulse) tmo_count++;
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("sb_data", 32'(tx_data), 32'(e[7:0]));
          chk("sb_grant", 32'(grant), 32'(e[9:8]));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_busy(input logic lvl);
    int n;
    n = 0;
    while (tx_busy !== lvl && n < 200) begin step(); n++; end
    chk("wait_busy", 32'(tx_busy), 32'(lvl));
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int n;
    n = 0;
    while (grant !== g && n < 200) begin step(); n++; end
    chk("wait_grant", 32'(grant), 32'(g));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && tx_busy == 1'b0 && grant == 2'b00) && n < 1000) begin step(); n++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    // Reset state
    step(); step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tmo", 32'(timeout_pulse), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    reset = 1'b0;
    step();

    // Simultaneous 2-byte packets after reset: req0 first.
    q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21});
    exp_q.push_back({2'b01, 8'h10}); exp_q.push_back({2'b01, 8'h11});
    exp_q.push_back({2'b10, 8'h20}); exp_q.push_back({2'b10, 8'h21});
    wait_drain();

    // Single-byte packet, cycle-accurate timing.
    q0.push_back({1'b1, 8'h41});
    exp_q.push_back({2'b01, 8'h41});
    step();                               // T: valid seen in IDLE
    chk("A_grant_T", 32'(grant), 32'd0);
    step();                               // T+1
    chk("A_grant_T1", 32'(grant), 32'(2'b01));
    chk("A_ready_T1", 32'(req0_ready), 32'd1);
    step();                               // T+2
    chk("A_start_T2", 32'(tx_start), 32'd1);
    chk("A_data_T2", 32'(tx_data), 32'h41);
    step();
    chk("A_start_T3", 32'(tx_start), 32'd0);
    chk("A_data_T3", 32'(tx_data), 32'h41);
    wait_busy(1'b1);
    wait_busy(1'b0);
    chk("A_grant_busy_fall", 32'(grant), 32'(2'b01));
    step();
    chk("A_grant_release", 32'(grant), 32'd0);
    wait_drain();

    // Fairness: prio now favours req1.
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b1, 8'hC0 + 8'(i)});
      q1.push_back({1'b1, 8'hD0 + 8'(i)});
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b10, 8'hD0 + 8'(i)});
      exp_q.push_back({2'b01, 8'hC0 + 8'(i)});
    end
    wait_drain();

    // Reset mid-packet (WAIT_DONE) with prio = 1 beforehand.
    q1.push_back({1'b1, 8'hE1});
    exp_q.push_back({2'b10, 8'hE1});
    wait_busy(1'b1);
    step();
    #1 reset = 1'b1;
    #1;
    chk("D_grant", 32'(grant), 32'd0);
    chk("D_tx_start", 32'(tx_start), 32'd0);
    chk("D_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("D_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    #3 reset = 1'b0;
    step();
    chk("D_grant_after", 32'(grant), 32'd0);
    wait_busy(1'b0);
    q0.push_back({1'b1, 8'h71});
    q1.push_back({1'b1, 8'h72});
    exp_q.push_back({2'b01, 8'h71});
    exp_q.push_back({2'b10, 8'h72});
    wait_drain();

    // Idle timeout (IDLE_TIMEOUT = 8) with req0 pending.
    q1.push_back({1'b0, 8'h55});
    exp_q.push_back({2'b10, 8'h55});
    wait_grant(2'b10);
    q0.push_back({1'b1, 8'hAA});
    exp_q.push_back({2'b01, 8'hAA});
    wait_busy(1'b1);
    wait_busy(1'b0);
    k = 0;
    while (k < 14 && !timeout_pulse) begin step(); k++; end
    chk("E_tmo_delay", 32'(k), 32'd9);
    chk("E_tmo_grant", 32'(grant), 32'd0);
    step();
    chk("E_tmo_once", 32'(timeout_pulse), 32'd0);
    chk("E_req0_granted", 32'(grant), 32'(2'b01));
    wait_drain();

    // Busy already high in OWN.
    force_busy = 1'b1;
    q0.push_back({1'b1, 8'hB7});
    exp_q.push_back({2'b01, 8'hB7});
    for (int i = 0; i < 6; i++) begin
      step();
      chk("F_no_ready", 32'(req0_ready), 32'd0);
      chk("F_no_start", 32'(tx_start), 32'd0);
    end
    chk("F_grant", 32'(grant), 32'(2'b01));
    force_busy = 1'b0;
    #1;
    chk("F_ready_after", 32'(req0_ready), 32'd1);
    wait_drain();

    chk("tmo_total", 32'(tmo_count), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
